// File: rtl/mux_n_rr_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
// The mux owns the slave view; whoever drives the producers and consumer uses the master view.
interface mux_n_rr_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(N)
);
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N-1:0]      in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_chan;
  logic              out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/mux_n_rr.sv
// N-channel registered valid/ready stream multiplexer with fixed or round-robin selection.
// Output beat carries the index of the channel that supplied it.
module mux_n_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(N)
) (
  input logic         clk,
  input logic         rst,
  mux_n_rr_if.slave   bus
);
  localparam logic [SELW:0]   N_W  = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0]  ptr_reg;
  logic [SELW-1:0]  ptr_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_chan_reg;

  logic [SELW-1:0]  cand_idx [N];
  logic [N-1:0]     cand_valid;
  logic [WIDTH-1:0] chan_data [N];
  logic [SELW-1:0]  rr_idx;
  logic             rr_found;
  logic             sel_ok;
  logic             have_grant;
  logic [SELW-1:0]  grant_idx;
  logic             load;

  // Offset gi from the pointer maps to channel (ptr + gi) mod N.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [SELW:0] sum;
    assign sum            = {1'b0, ptr_reg} + (SELW + 1)'(gi);
    assign cand_idx[gi]   = (sum >= N_W) ? SELW'(sum - N_W) : SELW'(sum);
    assign cand_valid[gi] = bus.in_valid[cand_idx[gi]];
    assign chan_data[gi]  = bus.in_data[gi*WIDTH +: WIDTH];
  end

  // Walk offsets from farthest to nearest so the closest valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx[k];
      end
    end
  end

  assign sel_ok     = ({1'b0, bus.sel} < N_W);
  assign have_grant = bus.mode ? rr_found : (sel_ok && bus.in_valid[bus.sel]);
  assign grant_idx  = bus.mode ? rr_idx : bus.sel;
  assign load       = have_grant && (!out_valid_reg || bus.out_ready);
  assign ptr_next   = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign bus.in_ready[gi] = load && !rst && (grant_idx == SELW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      ptr_reg       <= '0;
    end else begin
      if (load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= chan_data[grant_idx];
        out_chan_reg  <= grant_idx;
        if (bus.mode) begin
          ptr_reg <= ptr_next;
        end
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_chan  = out_chan_reg;
endmodule

// File: tb/tb_mux_n_rr.sv
// Directed-vector bench for mux_n_rr (N=4, WIDTH=8) with hand-computed expectations.
module tb_mux_n_rr;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mux_n_rr_if #(.N(4), .WIDTH(8)) bus ();
  mux_n_rr #(.N(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One accepted beat from channel ch: check ready now, then the registered output.
  task automatic beat(input string tag, input int ch);
    logic [3:0] rdy;
    rdy = 4'b0001 << ch;
    settle();
    check_eq({tag, " in_ready"}, 32'(bus.in_ready), 32'(rdy));
    tick();
    check_eq({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, " out_chan"}, 32'(bus.out_chan), 32'(ch));
    check_eq({tag, " out_data"}, 32'(bus.out_data), 32'(8'hA0 + ch));
  endtask

  initial begin
    int rr_seq [8];
    int alt_seq [4];
    rr_seq  = '{0, 1, 2, 3, 0, 1, 2, 3};
    alt_seq = '{1, 3, 1, 3};

    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.sel       = 2'd0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.out_ready = 1'b1;

    // 1 reset with every channel valid
    tick();
    tick();
    check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("reset out_data", 32'(bus.out_data), 32'd0);
    check_eq("reset out_chan", 32'(bus.out_chan), 32'd0);
    check_eq("reset in_ready", 32'(bus.in_ready), 32'd0);

    // 2 fixed select of channel 2, full throughput
    rst     = 1'b0;
    bus.sel = 2'd2;
    for (int i = 0; i < 3; i++) beat("fixed sel2", 2);

    // 3 round-robin from pointer 0, then sparse valid pattern
    bus.mode = 1'b1;
    for (int i = 0; i < 8; i++) beat("rr all", rr_seq[i]);
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) beat("rr 1010", alt_seq[i]);

    // 4 backpressure: ptr=0, load ch0 then stall three cycles
    bus.in_valid = 4'b1111;
    beat("bp load", 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("bp in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check_eq("bp hold valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp hold data", 32'(bus.out_data), 32'hA0);
      check_eq("bp hold chan", 32'(bus.out_chan), 32'd0);
    end
    bus.out_ready = 1'b1;
    beat("bp release", 1);

    // 5 wrap to ch3, fixed sel1 twice, resume round-robin at ch0
    beat("wrap", 2);
    beat("wrap", 3);
    bus.mode = 1'b0;
    bus.sel  = 2'd1;
    beat("switch sel1", 1);
    beat("switch sel1", 1);
    bus.mode = 1'b1;
    beat("resume rr", 0);
    bus.mode     = 1'b0;
    bus.sel      = 2'd3;
    bus.in_valid = 4'b0111;
    settle();
    check_eq("sel3 idle in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check_eq("sel3 idle out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("sel3 idle data hold", 32'(bus.out_data), 32'hA0);
    check_eq("sel3 idle chan hold", 32'(bus.out_chan), 32'd0);

    // no valid in round-robin leaves the pointer at 1
    bus.mode     = 1'b1;
    bus.in_valid = 4'b0000;
    settle();
    check_eq("none in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check_eq("none out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 4'b1111;
    beat("after idle", 1);

    // 6 reset while a beat is stalled
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    check_eq("midrst in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check_eq("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst out_data", 32'(bus.out_data), 32'd0);
    check_eq("midrst out_chan", 32'(bus.out_chan), 32'd0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    beat("post reset ptr0", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
